mem_rd_port: RTL and testbench

Data-memory access port that consumes the address held in the address register and completes the transfer. It latches the address and bus data, performs a write or a multi-cycle read of an internal `2**WIDTH`-word RAM, and returns read data to the shared bus. Bus drive is gated by a one-cycle enable. The datapath controller sequences it with a request/busy/done handshake.

---
 rtl/mem_rd_port.sv | 125 ++++++++++++
 tb/tb_mem_rd_port.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_port.sv
// Data-memory access port. Latches the address and data, then either writes the
// internal RAM or performs a multi-cycle read whose result is returned on MemOut.
module mem_rd_port #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 2
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] Addr,
   input  logic [WIDTH-1:0] BusOut,
   input  logic             RdReq,
   input  logic             WrReq,
   output logic [WIDTH-1:0] MemOut,
   output logic             BusEn,
   output logic             Busy,
   output logic             Done,
   output logic             Err,
   output logic [1:0]       DbgState
);

   // Handshake: RdReq/WrReq are sampled only while Busy is low. Busy rises in the
   // cycle after acceptance, Done pulses for one cycle at completion, and any
   // request seen while Busy is high is dropped rather than queued.

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RD_DONE = 2'd2,
      ST_WR      = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] mem_out_q, mem_out_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bus_en_q, bus_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] mem_q [2**WIDTH];

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      mem_out_d = mem_out_q;
      cnt_d     = cnt_q;
      err_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A simultaneous write request is dropped in favour of the read.
            if (RdReq) begin
               addr_d  = Addr;
               cnt_d   = CW'(LATENCY - 1);
               err_d   = WrReq;
               state_d = ST_RD_WAIT;
            end else if (WrReq) begin
               addr_d  = Addr;
               data_d  = BusOut;
               state_d = ST_WR;
            end
         end
         ST_RD_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               mem_out_d = mem_q[addr_q];
               state_d   = ST_RD_DONE;
            end
         end
         ST_RD_DONE: state_d = ST_IDLE;
         ST_WR:      state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      // Status outputs are registered from the next state so they line up with it.
      busy_d   = (state_d != ST_IDLE);
      done_d   = (state_d == ST_RD_DONE) || (state_d == ST_WR);
      bus_en_d = (state_d == ST_RD_DONE);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         mem_out_q <= '0;
         cnt_q     <= '0;
         bus_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         mem_out_q <= mem_out_d;
         cnt_q     <= cnt_d;
         bus_en_q  <= bus_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // RAM is not reset; a reset on the edge ending WR cancels the write.
   always_ff @(posedge Clk) begin
      if (!Rst && state_q == ST_WR) begin
         mem_q[addr_q] <= data_q;
      end
   end

   assign MemOut   = mem_out_q;
   assign BusEn    = bus_en_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Err      = err_q;
   assign DbgState = state_q;

endmodule

// File: tb/tb_mem_rd_port.sv
// Bench for mem_rd_port: three instances (LATENCY 2, 1, 4) share stimulus and are
// checked each cycle against a transaction-timeline model plus directed literals.
module tb_mem_rd_port;

   localparam int N = 3;

   logic             Clk = 1'b0;
   logic             Rst, RdReq, WrReq;
   logic [7:0]       Addr, BusOut;
   logic [7:0]       mem_out [N];
   logic [1:0]       dbg [N];
   logic [N-1:0]     bus_en, busy, done, err;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      mem_rd_port #(
         .WIDTH   (8),
         .LATENCY (g == 0 ? 2 : (g == 1 ? 1 : 4))
      ) u_dut (
         .Clk      (Clk),
         .Rst      (Rst),
         .Addr     (Addr),
         .BusOut   (BusOut),
         .RdReq    (RdReq),
         .WrReq    (WrReq),
         .MemOut   (mem_out[g]),
         .BusEn    (bus_en[g]),
         .Busy     (busy[g]),
         .Done     (done[g]),
         .Err      (err[g]),
         .DbgState (dbg[g])
      );
   end

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
   endfunction

   task automatic chk1(input string name, input int idx, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d actual=%b required=%b t=%0t", name, idx, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, idx, act, exp, $time);
      end
   endtask

   task automatic chkn(input string name, input int idx, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s dut%0d actual=%0d required=%0d", name, idx, act, exp);
      end
   endtask

   // Model: each operation is described by its age in cycles since acceptance.
   int         age [N];
   bit         kind_wr [N];
   logic [7:0] a_m [N];
   logic [7:0] d_m [N];
   logic [7:0] mo_m [N];
   bit         err_m [N];
   bit         mo_known [N];
   logic [7:0] mem_m [N][256];
   bit         known [N][256];
   bit         model_on = 1'b0;

   always @(posedge Clk) begin
      for (int i = 0; i < N; i++) begin
         if (Rst) begin
            age[i]      = 0;
            mo_m[i]     = 8'h00;
            mo_known[i] = 1'b1;
            err_m[i]    = 1'b0;
         end else begin
            err_m[i] = 1'b0;
            if (age[i] == 0) begin
               if (RdReq) begin
                  kind_wr[i] = 1'b0;
                  a_m[i]     = Addr;
                  err_m[i]   = WrReq;
                  age[i]     = 1;
               end else if (WrReq) begin
                  kind_wr[i] = 1'b1;
                  a_m[i]     = Addr;
                  d_m[i]     = BusOut;
                  age[i]     = 1;
               end
            end else if (kind_wr[i]) begin
               mem_m[i][a_m[i]] = d_m[i];
               known[i][a_m[i]] = 1'b1;
               age[i]           = 0;
            end else if (age[i] == lat_of(i) + 1) begin
               age[i] = 0;
            end else begin
               if (age[i] == lat_of(i)) begin
                  mo_m[i]     = mem_m[i][a_m[i]];
                  mo_known[i] = known[i][a_m[i]];
               end
               age[i]++;
            end
         end
      end
      if (Rst) model_on = 1'b1;
   end

   always @(negedge Clk) begin
      if (model_on) begin
         for (int i = 0; i < N; i++) begin
            logic rd_done, wr_done;
            rd_done = !kind_wr[i] && (age[i] == lat_of(i) + 1);
            wr_done = kind_wr[i] && (age[i] == 1);
            chk1("busy", i, busy[i], age[i] != 0);
            chk1("done", i, done[i], rd_done || wr_done);
            chk1("bus_en", i, bus_en[i], rd_done);
            chk1("err", i, err[i], err_m[i]);
            if (mo_known[i]) chk8("mem_out", i, mem_out[i], mo_m[i]);
         end
      end
   end

   task automatic wait_idle(input bit all_duts);
      int n = 0;
      while ((all_duts ? (busy != '0) : busy[0]) && n < 50) begin
         @(negedge Clk);
         n++;
      end
      total++;
      if (n >= 50) begin
         bad++;
         $display("FAIL idle_wait actual=busy state=%0d required=idle", dbg[0]);
      end
   endtask

   task automatic wr0(input logic [7:0] a, input logic [7:0] d, output logic d1, output logic b2);
      wait_idle(1'b0);
      WrReq  = 1'b1;
      Addr   = a;
      BusOut = d;
      @(negedge Clk);
      WrReq  = 1'b0;
      Addr   = 8'($urandom);
      BusOut = 8'($urandom);
      d1     = done[0];
      @(negedge Clk);
      b2     = busy[0];
   endtask

   task automatic wait_done0(output int n);
      n = 1;
      while (!done[0] && n < 20) begin
         @(negedge Clk);
         n++;
      end
   endtask

   task automatic rd0(input logic [7:0] a, output logic [7:0] d, output int n, output logic be);
      wait_idle(1'b0);
      RdReq = 1'b1;
      Addr  = a;
      @(negedge Clk);
      RdReq = 1'b0;
      Addr  = 8'($urandom);
      wait_done0(n);
      d  = mem_out[0];
      be = bus_en[0];
   endtask

   initial begin
      logic [7:0] d;
      logic       d1, b2, be;
      int         n, errs;
      int         first [N];
      int         second [N];

      Rst = 1'b1; RdReq = 1'b0; WrReq = 1'b0; Addr = 8'h00; BusOut = 8'h00;
      repeat (2) @(negedge Clk);
      chk8("rst_mem_out", 0, mem_out[0], 8'h00);
      chk1("rst_busy", 0, busy[0], 1'b0);
      chk1("rst_done", 0, done[0], 1'b0);
      chk1("rst_bus_en", 0, bus_en[0], 1'b0);
      chk1("rst_err", 0, err[0], 1'b0);
      Rst = 1'b0;

      for (int a = 0; a < 256; a++) wr0(8'(a), 8'(a) ^ 8'h5C, d1, b2);

      wr0(8'h3C, 8'hA5, d1, b2);
      chk1("wr_done_c1", 0, d1, 1'b1);
      chk1("wr_busy_c2", 0, b2, 1'b0);
      rd0(8'h3C, d, n, be);
      chkn("rd_latency", 0, n, 3);
      chk8("rd_data", 0, d, 8'hA5);
      chk1("rd_bus_en", 0, be, 1'b1);
      @(negedge Clk);
      chk1("rd_bus_en_drop", 0, bus_en[0], 1'b0);
      chk8("rd_hold", 0, mem_out[0], 8'hA5);

      wr0(8'h00, 8'h11, d1, b2);
      wr0(8'hFF, 8'h22, d1, b2);
      wait_idle(1'b0);
      RdReq = 1'b1; Addr = 8'h00;
      @(negedge Clk);
      RdReq = 1'b0; WrReq = 1'b1; Addr = 8'h00; BusOut = 8'h99;
      @(negedge Clk);
      WrReq = 1'b0;
      wait_done0(n);
      chk8("busy_rej_rd", 0, mem_out[0], 8'h11);
      rd0(8'h00, d, n, be);
      chk8("busy_rej_reread", 0, d, 8'h11);
      rd0(8'hFF, d, n, be);
      chk8("rd_ff", 0, d, 8'h22);

      wr0(8'h10, 8'h5A, d1, b2);
      wait_idle(1'b0);
      RdReq = 1'b1; WrReq = 1'b1; Addr = 8'h10; BusOut = 8'h77;
      @(negedge Clk);
      RdReq = 1'b0; WrReq = 1'b0;
      chk1("err_c1", 0, err[0], 1'b1);
      errs = 0;
      n = 1;
      while (!done[0] && n < 20) begin
         if (err[0]) errs++;
         @(negedge Clk);
         n++;
      end
      if (err[0]) errs++;
      chkn("err_pulses", 0, errs, 1);
      chk8("sim_rd", 0, mem_out[0], 8'h5A);
      rd0(8'h10, d, n, be);
      chk8("sim_ram_kept", 0, d, 8'h5A);

      wr0(8'h20, 8'h01, d1, b2);
      wait_idle(1'b0);
      WrReq = 1'b1; Addr = 8'h20; BusOut = 8'hEE;
      @(negedge Clk);
      chk1("rstwr_done", 0, done[0], 1'b1);
      WrReq = 1'b0; Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      chk1("rstwr_busy", 0, busy[0], 1'b0);
      chk8("rstwr_mem_out", 0, mem_out[0], 8'h00);
      rd0(8'h20, d, n, be);
      chk8("rstwr_no_write", 0, d, 8'h01);

      wait_idle(1'b1);
      for (int i = 0; i < N; i++) begin
         first[i]  = -1;
         second[i] = -1;
      end
      RdReq = 1'b1; Addr = 8'h3C;
      for (int c = 1; c <= 14; c++) begin
         @(negedge Clk);
         for (int i = 0; i < N; i++) begin
            if (done[i]) begin
               if (first[i] < 0) first[i] = c;
               else if (second[i] < 0) second[i] = c;
            end
         end
      end
      RdReq = 1'b0;
      chkn("sweep_first", 0, first[0], 3);
      chkn("sweep_period", 0, second[0] - first[0], 4);
      chkn("sweep_first", 1, first[1], 2);
      chkn("sweep_period", 1, second[1] - first[1], 3);
      chkn("sweep_first", 2, first[2], 5);
      chkn("sweep_period", 2, second[2] - first[2], 6);

      for (int c = 0; c < 3000; c++) begin
         @(negedge Clk);
         RdReq  = ($urandom_range(0, 3) == 0);
         WrReq  = ($urandom_range(0, 2) == 0);
         Addr   = 8'($urandom);
         BusOut = 8'($urandom);
         Rst    = ($urandom_range(0, 150) == 0);
      end
      @(negedge Clk);
      RdReq = 1'b0; WrReq = 1'b0; Rst = 1'b0;
      repeat (10) @(negedge Clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
